pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Detects load-use hazards,

---
 rtl/pipe_pkg.sv | 13 +
 rtl/haz_ld_use_det.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and the
// hard-wired zero register index.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/haz_ld_use_det.sv
// Load-use detector: flags an ID instruction that reads the destination of a
// load still sitting in EX. x0 never produces a hazard.
module haz_ld_use_det
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_valid,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    output logic       ld_use
);

    logic ex_is_load_wr;
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        ex_is_load_wr = ex_valid & ex_mem_read & ex_reg_write & (ex_rd != REG_X0);
        rs1_hit       = id_use_rs1 & (id_rs1 == ex_rd);
        rs2_hit       = id_use_rs2 & (id_rs2 == ex_rd);
        ld_use        = ex_is_load_wr & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline with a dmem watchdog.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TMO_CYCLES = 255,
`ifdef HAZ_PERF_CNT_EN
    parameter int CNT_W      = 32,
`endif
    parameter int TMO_W      = 8
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_reg_write,
    input  logic            ex_br_taken,
    input  logic [XLEN-1:0] ex_br_target,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            pc_stall,
    output logic            if_id_stall,
    output logic            if_id_flush,
    output logic            id_ex_stall,
    output logic            id_ex_flush,
    output logic            ex_mem_stall,
    output logic            mem_wb_flush,
    output logic            redirect_vld,
    output logic [XLEN-1:0] redirect_pc,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_lu_cnt,
    output logic [CNT_W-1:0] perf_br_cnt,
    output logic [CNT_W-1:0] perf_wait_cnt,
`endif
    output logic            mem_err
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam logic [TMO_W-1:0] CNT_SAT  = '1;

    hz_state_e        state_q, state_d;
    logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             dmem_wait;
    logic             ld_use;
    logic             freeze;
    logic             branch;
    logic             lu_bubble;

    haz_ld_use_det u_ld_use (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ld_use       (ld_use)
    );

    assign dmem_wait = mem_req & ~mem_ready;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Watchdog: counter only moves in WAIT and saturates instead of wrapping.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (dmem_wait) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    if (dmem_wait && (wait_cnt_q == TMO_LAST)) state_d = ST_ERR;
                    if (wait_cnt_q != CNT_SAT) wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_RUN;
        endcase
    end

    // Priority: freeze > taken branch > load-use. Everything is gated by rst_
    // so the pipeline sees quiet controls while reset is held.
    always_comb begin
        freeze    = rst_ & (dmem_wait | (state_q == ST_ERR));
        branch    = rst_ & ~freeze & ex_valid & ex_br_taken;
        lu_bubble = rst_ & ~freeze & ~branch & ld_use;

        pc_stall     = freeze | lu_bubble;
        if_id_stall  = freeze | lu_bubble;
        if_id_flush  = branch;
        id_ex_stall  = freeze;
        id_ex_flush  = branch | lu_bubble;
        ex_mem_stall = freeze;
        mem_wb_flush = freeze;
        redirect_vld = branch;
        redirect_pc  = branch ? ex_br_target : '0;
        mem_err      = rst_ & (state_q == ST_ERR);
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lu_q, perf_lu_d;
    logic [CNT_W-1:0] perf_br_q, perf_br_d;
    logic [CNT_W-1:0] perf_wait_q, perf_wait_d;

    always_comb begin
        perf_lu_d   = perf_lu_q + CNT_W'(lu_bubble);
        perf_br_d   = perf_br_q + CNT_W'(branch);
        perf_wait_d = perf_wait_q + CNT_W'(freeze);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            perf_lu_q   <= '0;
            perf_br_q   <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_lu_q   <= perf_lu_d;
            perf_br_q   <= perf_br_d;
            perf_wait_q <= perf_wait_d;
        end
    end

    assign perf_lu_cnt   = perf_lu_q;
    assign perf_br_cnt   = perf_br_q;
    assign perf_wait_cnt = perf_wait_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes expected controls,
// a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam logic [8:0] E_PC_ST    = 9'b100000000;
    localparam logic [8:0] E_IFID_ST  = 9'b010000000;
    localparam logic [8:0] E_IFID_FL  = 9'b001000000;
    localparam logic [8:0] E_IDEX_ST  = 9'b000100000;
    localparam logic [8:0] E_IDEX_FL  = 9'b000010000;
    localparam logic [8:0] E_EXMEM_ST = 9'b000001000;
    localparam logic [8:0] E_MEMWB_FL = 9'b000000100;
    localparam logic [8:0] E_RDR      = 9'b000000010;
    localparam logic [8:0] E_ERR      = 9'b000000001;
    localparam logic [8:0] NONE = 9'b0;
    localparam logic [8:0] LU   = E_PC_ST | E_IFID_ST | E_IDEX_FL;
    localparam logic [8:0] BR   = E_RDR | E_IFID_FL | E_IDEX_FL;
    localparam logic [8:0] FRZ  = E_PC_ST | E_IFID_ST | E_IDEX_ST | E_EXMEM_ST | E_MEMWB_FL;

    logic        clk = 1'b0;
    logic        rst_;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_valid, ex_mem_read, ex_reg_write;
    logic        ex_br_taken, mem_req, mem_ready;
    logic [31:0] ex_br_target;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, mem_wb_flush, redirect_vld, mem_err;
    logic [31:0] redirect_pc;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_lu_cnt, perf_br_cnt, perf_wait_cnt;
    int          m_lu = 0, m_br = 0, m_wt = 0;
`endif

    typedef struct {
        string       name;
        logic [8:0]  flags;
        logic [31:0] pc;
`ifdef HAZ_PERF_CNT_EN
        int          lu, br, wt;
`endif
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst_         (rst_),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_br_taken  (ex_br_taken),
        .ex_br_target (ex_br_target),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_stall (ex_mem_stall),
        .mem_wb_flush (mem_wb_flush),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
`ifdef HAZ_PERF_CNT_EN
        .perf_lu_cnt  (perf_lu_cnt),
        .perf_br_cnt  (perf_br_cnt),
        .perf_wait_cnt(perf_wait_cnt),
`endif
        .mem_err      (mem_err)
    );

    // Monitor: controls are combinational, so every pushed cycle is compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [8:0] got;
            e   = sb.pop_front();
            got = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                   ex_mem_stall, mem_wb_flush, redirect_vld, mem_err};
            n_chk++;
            if (got !== e.flags)
                $display("FAIL %s ctrl: got %b expected %b", e.name, got, e.flags);
            else
                n_pass++;
            n_chk++;
            if (redirect_pc !== e.pc)
                $display("FAIL %s redirect_pc: got %h expected %h", e.name, redirect_pc, e.pc);
            else
                n_pass++;
`ifdef HAZ_PERF_CNT_EN
            n_chk++;
            if (perf_lu_cnt !== 32'(e.lu) || perf_br_cnt !== 32'(e.br) || perf_wait_cnt !== 32'(e.wt))
                $display("FAIL %s perf: got %0d/%0d/%0d expected %0d/%0d/%0d", e.name,
                         perf_lu_cnt, perf_br_cnt, perf_wait_cnt, e.lu, e.br, e.wt);
            else
                n_pass++;
`endif
        end
    end

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_valid = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        ex_br_taken = 1'b0; ex_br_target = 32'h0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic load_in_ex(input logic [4:0] rd);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
    endtask

    // Push the expectation for the inputs currently driven, then advance one cycle.
    task automatic cyc(input logic [8:0] f, input logic [31:0] pc, input string nm);
        exp_t e;
        e.name = nm; e.flags = f; e.pc = pc;
`ifdef HAZ_PERF_CNT_EN
        if (!rst_) begin m_lu = 0; m_br = 0; m_wt = 0; end
        e.lu = m_lu; e.br = m_br; e.wt = m_wt;
        if (f == LU) m_lu++;
        if ((f & E_RDR) != 0) m_br++;
        if ((f & E_EXMEM_ST) != 0) m_wt++;
`endif
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_ = 1'b0;
        idle();
        @(posedge clk); #1;

        // Outputs must stay quiet under reset even with hazards on the inputs.
        mem_req = 1'b1; ex_valid = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h40;
        cyc(NONE, 32'h0, "reset_hold");
        cyc(NONE, 32'h0, "reset_hold2");
        rst_ = 1'b1; idle();
        cyc(NONE, 32'h0, "post_reset_idle");

        // Load-use via rs2, then via rs1.
        load_in_ex(5'd5); id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        cyc(LU, 32'h0, "lu_rs2");
        idle(); id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        cyc(NONE, 32'h0, "lu_release");
        idle(); load_in_ex(5'd7); id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        cyc(LU, 32'h0, "lu_rs1");

        // Non-hazards: x0, unused source, non-writing instr.
        idle(); load_in_ex(5'd0); id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        cyc(NONE, 32'h0, "x0_no_haz");
        idle(); load_in_ex(5'd5); id_rs1 = 5'd5; id_use_rs1 = 1'b0;
        cyc(NONE, 32'h0, "rs1_unused");
        ex_reg_write = 1'b0; id_use_rs1 = 1'b1;
        cyc(NONE, 32'h0, "no_reg_write");

        // Branch beats load-use.
        idle(); load_in_ex(5'd5); id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        ex_br_taken = 1'b1; ex_br_target = 32'h0000_0040;
        cyc(BR, 32'h40, "br_over_lu");
        ex_valid = 1'b0;
        cyc(NONE, 32'h0, "br_ex_invalid");

        // Three wait cycles holding a taken branch, then release.
        idle(); ex_valid = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h80;
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc(FRZ, 32'h0, "wait1");
        cyc(FRZ, 32'h0, "wait2");
        cyc(FRZ, 32'h0, "wait3");
        mem_ready = 1'b1;
        cyc(BR, 32'h80, "wait_release_br");
        idle();
        cyc(NONE, 32'h0, "after_wait_idle");

        // Freeze outranks load-use; zero-wait access is transparent.
        load_in_ex(5'd9); id_rs1 = 5'd9; id_use_rs1 = 1'b1; mem_req = 1'b1; mem_ready = 1'b1;
        cyc(LU, 32'h0, "zero_wait_lu");
        mem_ready = 1'b0;
        cyc(FRZ, 32'h0, "frz_over_lu");
        mem_ready = 1'b1;
        cyc(LU, 32'h0, "frz_release_lu");
        idle();
        cyc(NONE, 32'h0, "idle2");

        // Watchdog: one RUN cycle then 255 WAIT cycles, ERR afterwards.
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k <= 255; k++) cyc(FRZ, 32'h0, "tmo_wait");
        cyc(FRZ | E_ERR, 32'h0, "tmo_err");
        idle(); ex_valid = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h40;
        cyc(FRZ | E_ERR, 32'h0, "err_sticky");
        rst_ = 1'b0;
        cyc(NONE, 32'h0, "err_reset");
        rst_ = 1'b1;
        cyc(BR, 32'h40, "err_cleared_br");
        idle(); mem_req = 1'b1;
        cyc(FRZ, 32'h0, "wait_after_err");
        idle();
        cyc(NONE, 32'h0, "final_idle");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
